seg_scan: RTL and testbench
===========================

SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter SCAN_DIV, default 10000, clk cycles per digit slot (1 kHz slot rate at 10 MHz); legal range 4..65535.
REQ-002 Parameter BLANK_CYCLES, default 16, anti-ghost blank cycles at the start of each slot; SHALL be < SCAN_DIV.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 ena  input  1  scan enable; low freezes scanning and blanks the display.
REQ-006 load  input  1  single-cycle strobe capturing digits_in/dp_in into the pending buffer.
REQ-007 digits_in  input  16  four BCD nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-008 dp_in  input  4  decimal point per digit, bit n for digit n.
REQ-009 segments  output  7  active-high segments, bit 0 = top, clockwise a..f, bit 6 = middle.
REQ-010 dp  output  1  active-high decimal point for the selected digit.
REQ-011 digit_sel  output  4  one-hot active-high digit enable, or all-zero when blanked.
REQ-012 frame  output  1  one-cycle pulse when the slot index wraps 3->0.

Function
REQ-013 Prescaler counts 0..SCAN_DIV-1; tick = (count == SCAN_DIV-1); count wraps to 0 on tick.
REQ-014 Slot index (2 bits) increments on tick, wrapping 3->0; frame asserts in the cycle after the tick that wraps 3->0.
REQ-015 load writes the pending buffer and sets pending flag; a later load before the frame wrap overwrites it (last-wins).
REQ-016 On the 3->0 wrap tick with pending set, the pending buffer copies into the display register and pending clears.
REQ-017 load coincident with the wrap tick: the just-loaded values go directly to the display register; pending stays clear.
REQ-018 Display register changes only at frame wraps; no mid-frame update (no tearing).
REQ-019 Outputs registered: segments/dp/digit_sel reflect slot index and prescaler value with exactly one cycle latency.
REQ-020 digit_sel = 0 while prescaler < BLANK_CYCLES; otherwise bit [index] set.
REQ-021 segments decode: 0-9 standard 7-segment patterns; 10-15 -> 7'b0000000.
REQ-022 segments = 0 and dp = 0 whenever digit_sel = 0.
REQ-023 ena low: prescaler and index hold, digit_sel/segments/dp = 0, frame = 0; load still captured; scanning resumes from the held state one cycle after ena rises.

Reset
REQ-024 reset asserted: prescaler 0, index 0, display register 0, pending buffer 0, pending flag 0, segments 0, dp 0, digit_sel 0, frame 0.
REQ-025 reset mid-frame discards pending data; first slot after release is digit 0 with BLANK_CYCLES blanking.

Configuration
REQ-026 Macro SEG_SCAN_LZB_EN defined: leading-zero blanking -- digit n (n = 3..1) shows segments 0 if it and all higher digits are 0; digit 0 never blanked; dp unaffected.
REQ-027 Macro SEG_SCAN_LZB_EN undefined: all digits always decoded, zeros shown.

Structure
REQ-028 Shared package seg_pkg holds the 7-bit segment pattern constants (digits 0-9, blank) and the slot-index type.
REQ-029 One sub-module, scan_seg_decode (4-bit BCD + blank in -> 7-bit segments out), purely combinational.

Verification (SCAN_DIV=8, BLANK_CYCLES=2)
REQ-030 reset, load digits_in=16'h1234, dp_in=0 -> after first wrap, slots show 4,3,2,1 with digit_sel 0001,0010,0100,1000; each selected 6 of 8 cycles.
REQ-031 Two loads mid-frame (16'h0005 then 16'h0987) -> current frame unchanged; next frame shows 0987 only.
REQ-032 load 16'h0042 on the wrap-tick cycle -> new values shown starting at digit 0 of the immediately following frame.
REQ-033 digits_in=16'h0007: with SEG_SCAN_LZB_EN, digits 3..1 segments 0, digit 0 = 7'b0000111; without it, digits 3..1 = 7'b0111111.
REQ-034 digits_in=16'hA000, ena dropped 3 cycles mid-slot -> digit 3 segments 0; during ena low all outputs 0, slot resumes at held count.
REQ-035 reset asserted mid-slot 2 with pending set -> outputs 0 asynchronously; after release digit 0 shows 0, pending discarded.

Source files
------------

// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the seg_scan display multiplexer.
//   - slot_idx_t : 2-bit index of the digit currently being scanned
//   - SEG_0..SEG_9, SEG_BLANK : active-high 7-segment patterns,
//     bit 0 = segment a (top), clockwise through f, bit 6 = g (middle)
// ---------------------------------------------------------------------------
package seg_pkg;

    typedef logic [1:0] slot_idx_t;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/scan_seg_decode.sv
// ---------------------------------------------------------------------------
// scan_seg_decode
// Purely combinational BCD to 7-segment decoder.
// Ports:
//   i_bcd      [3:0]  BCD digit; codes 10-15 decode to an all-off pattern
//   i_blank           forces an all-off pattern (leading-zero suppression)
//   o_segments [6:0]  active-high segments a..g (bit 0 = a, bit 6 = g)
// ---------------------------------------------------------------------------
module scan_seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] i_bcd,
    input  logic       i_blank,
    output logic [6:0] o_segments
);

    // Look up the segment pattern; anything that is not a valid decimal
    // digit is shown dark rather than as a hex glyph.
    always_comb begin
        o_segments = SEG_BLANK;
        if (!i_blank) begin
            case (i_bcd)
                4'd0:    o_segments = SEG_0;
                4'd1:    o_segments = SEG_1;
                4'd2:    o_segments = SEG_2;
                4'd3:    o_segments = SEG_3;
                4'd4:    o_segments = SEG_4;
                4'd5:    o_segments = SEG_5;
                4'd6:    o_segments = SEG_6;
                4'd7:    o_segments = SEG_7;
                4'd8:    o_segments = SEG_8;
                4'd9:    o_segments = SEG_9;
                default: o_segments = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/seg_scan.sv
// ---------------------------------------------------------------------------
// seg_scan
// Four-digit multiplexed 7-segment display scanner with a double-buffered
// digit register that only changes on frame boundaries (no tearing).
// Parameters:
//   SCAN_DIV      clock cycles per digit slot (4..65535)
//   BLANK_CYCLES  dark cycles at the start of every slot (< SCAN_DIV)
// Ports:
//   i_clk, i_reset        clock, asynchronous active-high reset
//   i_ena                 scan enable; low freezes scanning and darkens outputs
//   i_load                one-cycle strobe capturing i_digits_in / i_dp_in
//   i_digits_in [15:0]    four BCD nibbles, [3:0] = digit 0 (rightmost)
//   i_dp_in     [3:0]     decimal point per digit
//   o_segments  [6:0]     active-high segments of the selected digit
//   o_dp                  active-high decimal point of the selected digit
//   o_digit_sel [3:0]     one-hot digit enable, zero while blanked
//   o_frame               one-cycle pulse after the slot index wraps 3->0
// Build option:
//   SEG_SCAN_LZB_EN       when defined, leading zeros on digits 3..1 are dark
// ---------------------------------------------------------------------------
module seg_scan
    import seg_pkg::*;
#(
    parameter int SCAN_DIV     = 10000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_ena,
    input  logic        i_load,
    input  logic [15:0] i_digits_in,
    input  logic [3:0]  i_dp_in,
    output logic [6:0]  o_segments,
    output logic        o_dp,
    output logic [3:0]  o_digit_sel,
    output logic        o_frame
);

    localparam int                CNT_W     = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] r_count;
    slot_idx_t        r_index;
    logic [15:0]      r_display;
    logic [3:0]       r_displayDp;
    logic [15:0]      r_pending;
    logic [3:0]       r_pendingDp;
    logic             r_pendFlag;
    logic [6:0]       r_segments;
    logic             r_dp;
    logic [3:0]       r_digitSel;
    logic             r_frame;

    logic             w_tick;
    logic             w_wrap;
    logic             w_visible;
    logic [3:0]       w_digit;
    logic             w_blankLz;
    logic [6:0]       w_seg;

    assign w_tick    = i_ena && (r_count == CNT_LAST);
    assign w_wrap    = w_tick && (r_index == 2'd3);
    assign w_visible = i_ena && (r_count >= BLANK_END);
    assign w_digit   = r_display[{r_index, 2'b00} +: 4];

    // Prescaler and slot index both freeze while scanning is disabled, so
    // the display picks up exactly where it left off.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
            r_index <= 2'd0;
        end else if (w_tick) begin
            r_count <= '0;
            r_index <= r_index + 2'd1;
        end else if (i_ena) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Double buffer: loads land in the pending buffer and are promoted at
    // the frame wrap. A load on the wrap cycle itself bypasses the pending
    // buffer so the newest value is never delayed by a whole frame.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_display   <= '0;
            r_displayDp <= '0;
            r_pending   <= '0;
            r_pendingDp <= '0;
            r_pendFlag  <= 1'b0;
        end else if (i_load && w_wrap) begin
            r_display   <= i_digits_in;
            r_displayDp <= i_dp_in;
            r_pendFlag  <= 1'b0;
        end else if (i_load) begin
            r_pending   <= i_digits_in;
            r_pendingDp <= i_dp_in;
            r_pendFlag  <= 1'b1;
        end else if (w_wrap && r_pendFlag) begin
            r_display   <= r_pending;
            r_displayDp <= r_pendingDp;
            r_pendFlag  <= 1'b0;
        end
    end

`ifdef SEG_SCAN_LZB_EN
    // A digit is a leading zero when it and every digit to its left are
    // zero; the rightmost digit always shows so zero reads as "0".
    always_comb begin
        w_blankLz = 1'b0;
        case (r_index)
            2'd3:    w_blankLz = (r_display[15:12] == 4'd0);
            2'd2:    w_blankLz = (r_display[15:8]  == 8'd0);
            2'd1:    w_blankLz = (r_display[15:4]  == 12'd0);
            default: w_blankLz = 1'b0;
        endcase
    end
`else
    assign w_blankLz = 1'b0;
`endif

    scan_seg_decode u_decode (
        .i_bcd      (w_digit),
        .i_blank    (w_blankLz),
        .o_segments (w_seg)
    );

    // Output stage: one cycle behind the prescaler/index. The dark window at
    // the start of each slot lets the previous digit's driver turn off
    // before the next digit is enabled (anti-ghosting).
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_digitSel <= '0;
            r_segments <= '0;
            r_dp       <= 1'b0;
            r_frame    <= 1'b0;
        end else begin
            r_digitSel <= w_visible ? (4'b0001 << r_index) : 4'b0000;
            r_segments <= w_visible ? w_seg : SEG_BLANK;
            r_dp       <= w_visible && r_displayDp[r_index];
            r_frame    <= w_wrap;
        end
    end

    // Disabling the scan darkens the display immediately instead of leaving
    // the last registered digit lit for one more cycle.
    assign o_digit_sel = r_digitSel & {4{i_ena}};
    assign o_segments  = r_segments & {7{i_ena}};
    assign o_dp        = r_dp & i_ena;
    assign o_frame     = r_frame & i_ena;

endmodule

// File: tb/tb_seg_scan.sv
// ---------------------------------------------------------------------------
// tb_seg_scan
// Self-checking bench for seg_scan (SCAN_DIV=8, BLANK_CYCLES=2). A cycle
// level reference model tracks slot position, display and pending buffers;
// every cycle the DUT outputs are compared to what that model predicts.
// Honours SEG_SCAN_LZB_EN in its expectations.
// ---------------------------------------------------------------------------
module tb_seg_scan;

    localparam int SCAN_DIV     = 8;
    localparam int BLANK_CYCLES = 2;

    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic        ena      = 1'b0;
    logic        load     = 1'b0;
    logic [15:0] digitsIn = '0;
    logic [3:0]  dpIn     = '0;
    logic [6:0]  segments;
    logic        dp;
    logic [3:0]  digitSel;
    logic        frame;

    int checks   = 0;
    int failures = 0;
    string stepTag = "init";

    // Reference model state
    int          mCount;
    int          mIndex;
    logic [15:0] mDisp;
    logic [3:0]  mDispDp;
    logic [15:0] mPend;
    logic [3:0]  mPendDp;
    bit          mPendFlag;

    logic [3:0]  expSel;
    logic [6:0]  expSeg;
    logic        expDp;
    logic        expFrame;

    logic [6:0] segTable [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F,
                                  7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

    seg_scan #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_ena       (ena),
        .i_load      (load),
        .i_digits_in (digitsIn),
        .i_dp_in     (dpIn),
        .o_segments  (segments),
        .o_dp        (dp),
        .o_digit_sel (digitSel),
        .o_frame     (frame)
    );

    always #5 clk = ~clk;

    // Expected glyph for digit n of a display word, including leading-zero
    // suppression when that build option is on.
    function automatic logic [6:0] refSegments(input logic [15:0] disp, input int n);
        logic [15:0] upper;
        upper = disp >> (4 * n);
`ifdef SEG_SCAN_LZB_EN
        if (n > 0 && upper == 16'h0000) return 7'h00;
`endif
        return segTable[upper[3:0]];
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input logic [3:0] eSel, input logic [6:0] eSeg,
                            input logic eDp, input logic eFrame);
        checkOutput({stepTag, ".digit_sel"}, {4'h0, digitSel}, {4'h0, eSel});
        checkOutput({stepTag, ".segments"},  {1'b0, segments}, {1'b0, eSeg});
        checkOutput({stepTag, ".dp"},        {7'h0, dp},       {7'h0, eDp});
        checkOutput({stepTag, ".frame"},     {7'h0, frame},    {7'h0, eFrame});
    endtask

    // One clock cycle: drive inputs, predict the outputs of the following
    // cycle from the model's current position, advance the model, compare.
    task automatic applyStimulus(input bit e, input bit l, input logic [15:0] d, input logic [3:0] p);
        bit wrapNow;
        ena      = e;
        load     = l;
        digitsIn = d;
        dpIn     = p;
        wrapNow  = e && (mCount == SCAN_DIV - 1) && (mIndex == 3);
        if (e && mCount >= BLANK_CYCLES) begin
            expSel = 4'b0001 << mIndex;
            expSeg = refSegments(mDisp, mIndex);
            expDp  = mDispDp[mIndex];
        end else begin
            expSel = 4'b0000;
            expSeg = 7'h00;
            expDp  = 1'b0;
        end
        expFrame = wrapNow;
        @(posedge clk);
        #1;
        if (e) begin
            if (mCount == SCAN_DIV - 1) begin
                mCount = 0;
                mIndex = (mIndex + 1) % 4;
            end else begin
                mCount++;
            end
        end
        if (l && wrapNow) begin
            mDisp     = d;
            mDispDp   = p;
            mPendFlag = 0;
        end else if (l) begin
            mPend     = d;
            mPendDp   = p;
            mPendFlag = 1;
        end else if (wrapNow && mPendFlag) begin
            mDisp     = mPend;
            mDispDp   = mPendDp;
            mPendFlag = 0;
        end
        load = 1'b0;
        checkAll(expSel, expSeg, expDp, expFrame);
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b1, 1'b0, 16'($urandom), 4'($urandom));
    endtask

    // Assert reset between clock edges; outputs must clear without waiting
    // for a clock.
    task automatic doReset();
        reset = 1'b1;
        #1;
        stepTag = {stepTag, ".async_reset"};
        checkAll(4'h0, 7'h00, 1'b0, 1'b0);
        mCount    = 0;
        mIndex    = 0;
        mDisp     = '0;
        mDispDp   = '0;
        mPend     = '0;
        mPendDp   = '0;
        mPendFlag = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Advance until the model sits at the requested slot/count (bounded).
    task automatic runTo(input int idx, input int cnt);
        int guard = 0;
        while (!(mIndex == idx && mCount == cnt) && guard < 64) begin
            idle(1);
            guard++;
        end
    endtask

    initial begin
        int selCount [4];
        int frameCount;

        #2;
        stepTag = "reset";
        doReset();

        // Load 1234 and let the first wrap pick it up
        stepTag = "load1234";
        applyStimulus(1'b1, 1'b1, 16'h1234, 4'h0);
        idle(34);

        // Over one full frame each digit is lit 6 of 8 cycles, one frame pulse
        stepTag = "frame1234";
        foreach (selCount[i]) selCount[i] = 0;
        frameCount = 0;
        for (int c = 0; c < 4 * SCAN_DIV; c++) begin
            idle(1);
            for (int k = 0; k < 4; k++) if (digitSel[k]) selCount[k]++;
            if (frame) frameCount++;
        end
        for (int k = 0; k < 4; k++)
            checkOutput($sformatf("dutyDigit%0d", k), 8'(selCount[k]), 8'd6);
        checkOutput("framePulses", 8'(frameCount), 8'd1);

        // Two loads inside one frame: last one wins, shown from the next frame
        stepTag = "lastWins";
        runTo(1, 3);
        applyStimulus(1'b1, 1'b1, 16'h0005, 4'h2);
        idle(3);
        applyStimulus(1'b1, 1'b1, 16'h0987, 4'h1);
        idle(70);

        // Load exactly on the wrap tick goes straight to the display
        stepTag = "wrapLoad";
        runTo(3, SCAN_DIV - 1);
        applyStimulus(1'b1, 1'b1, 16'h0042, 4'h1);
        idle(34);

        // Leading zeros (dark only when the build option is on)
        stepTag = "lzb0007";
        applyStimulus(1'b1, 1'b1, 16'h0007, 4'h0);
        idle(70);

        // Invalid BCD digit and a 3-cycle enable drop mid-slot
        stepTag = "enaDrop";
        applyStimulus(1'b1, 1'b1, 16'hA000, 4'h8);
        idle(40);
        runTo(3, 4);
        repeat (3) applyStimulus(1'b0, 1'b0, 16'h0, 4'h0);
        idle(40);

        // Reset mid slot 2 with a pending update that must be discarded
        stepTag = "midReset";
        runTo(1, 5);
        applyStimulus(1'b1, 1'b1, 16'h5678, 4'hF);
        runTo(2, 4);
        doReset();
        stepTag = "postReset";
        idle(70);

        // Random enable/load traffic against the model
        stepTag = "random";
        for (int c = 0; c < 400; c++) begin
            applyStimulus(($urandom_range(0, 9) != 0), ($urandom_range(0, 15) == 0),
                          16'($urandom), 4'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
